// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction register and stop request in,
// register-select strobes, datapath strobes and ALU operation out.
interface control_unit_if;
  logic [31:0] IR;
  logic        Stop;
  logic        Run;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic        PCin, PCout, MARin, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read;
  logic [3:0]  ALUop;

  modport master (
    input  IR, Stop,
    output Run, Gra, Grb, Grc, Rin, Rout,
    output PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
    output Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read,
    output ALUop
  );

  modport slave (
    output IR, Stop,
    input  Run, Gra, Grb, Grc, Rin, Rout,
    input  PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
    input  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read,
    input  ALUop
  );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the fetch/execute datapath: fetch in T0-T2, then a
// per-opcode-class execute sequence; opcode 14 parks the machine in HALT.
//
// state | meaning
// IDLE  | after clear, all strobes low
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC, memory read into MDR
// T2    | MDR -> IR
// T3-T6 | execute steps, depending on opcode class
// HALT  | stopped, Run low, left only through clear
module control_unit (
  input  logic            clock,
  input  logic            clear,
  control_unit_if.master  bus
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t     state;
  state_t     end_of_instr;
  logic [4:0] opcode;
  logic       is_alu, is_muldiv, is_negnot, is_halt;

  assign opcode    = bus.IR[31:27];
  assign is_alu    = (opcode <= 5'd8);
  assign is_muldiv = (opcode == 5'd9) || (opcode == 5'd10);
  assign is_negnot = (opcode == 5'd11) || (opcode == 5'd12);
  assign is_halt   = (opcode == 5'd14);

  // Stop only matters on the edge that leaves an instruction's last state.
  assign end_of_instr = bus.Stop ? HALT : T0;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= T0;
        T0:   state <= T1;
        T1:   state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_halt)                           state <= HALT;
          else if (is_alu || is_muldiv || is_negnot) state <= T4;
          else                                   state <= end_of_instr;
        end
        T4:   state <= is_negnot ? end_of_instr : T5;
        T5:   state <= is_muldiv ? T6 : end_of_instr;
        T6:   state <= end_of_instr;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Run = (state != HALT);

  // The datapath IR loads on the edge leaving T2, so T3 strobes cannot be
  // precomputed a cycle early; decode is from the state register and the IR.
  always_comb begin
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.PCin     = 1'b0;
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zlowin   = 1'b0;
    bus.Zhighin  = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.ALUop    = 4'd0;
    case (state)
      T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end else if (is_negnot) begin
          bus.Grb    = 1'b1;
          bus.Rout   = 1'b1;
          bus.Zlowin = 1'b1;
          bus.ALUop  = opcode[3:0];
        end
      end
      T4: begin
        if (is_alu) begin
          bus.Grc    = 1'b1;
          bus.Rout   = 1'b1;
          bus.Zlowin = 1'b1;
          bus.ALUop  = opcode[3:0];
        end else if (is_muldiv) begin
          bus.Grb     = 1'b1;
          bus.Rout    = 1'b1;
          bus.Zlowin  = 1'b1;
          bus.Zhighin = 1'b1;
          bus.ALUop   = opcode[3:0];
        end else if (is_negnot) begin
          bus.Zlowout = 1'b1;
          bus.Gra     = 1'b1;
          bus.Rin     = 1'b1;
        end
      end
      T5: begin
        if (is_alu) begin
          bus.Zlowout = 1'b1;
          bus.Gra     = 1'b1;
          bus.Rin     = 1'b1;
        end else if (is_muldiv) begin
          bus.Zlowout = 1'b1;
          bus.LOin    = 1'b1;
        end
      end
      T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port IR, input, 32 bits: the instruction register contents from the datapath. Fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-004 The block SHALL have port Stop, input, 1 bit: halt request.
REQ-005 The block SHALL have port Run, output, 1 bit: high whenever the state is not HALT.
REQ-006 The block SHALL have ports Gra, Grb, Grc, Rin, Rout, outputs, 1 bit each: register-field select and enable strobes for the datapath select/encode logic.
REQ-007 The block SHALL have ports PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC, Read, outputs, 1 bit each: datapath control strobes.
REQ-008 The block SHALL have port ALUop, output, 4 bits: ALU operation code. ADD=0, SUB=1, AND=2, OR=3, ROR=4, ROL=5, SHR=6, SHL=7, SHRA=8, MUL=9, DIV=10, NEG=11, NOT=12.

Function
REQ-009 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; outputs are decoded from the state and the latched IR only.
REQ-010 Every output SHALL be 0 in any state or cycle not listed below, except Run; ALUop SHALL be 0 unless stated otherwise.
REQ-011 IDLE SHALL drive all strobes low and SHALL go to T0 on the next edge.
REQ-012 T0 SHALL assert PCout, MARin, IncPC and Zlowin, then go to T1.
REQ-013 T1 SHALL assert Zlowout, PCin, Read and MDRin, then go to T2.
REQ-014 T2 SHALL assert MDRout and IRin, then go to T3; decoding from T3 onward SHALL use the IR value loaded at the end of T2.
REQ-015 Three-register ops (opcode 0-8, ALUop = opcode[3:0]) SHALL run:
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, ALUop, Zlowin
  - T5: Zlowout, Gra, Rin
  - then T0
REQ-016 MUL/DIV (opcode 9/10) SHALL run:
  - T3: Gra, Rout, Yin
  - T4: Grb, Rout, ALUop, Zlowin, Zhighin
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin
  - then T0
REQ-017 NEG/NOT (opcode 11/12) SHALL run:
  - T3: Grb, Rout, ALUop, Zlowin
  - T4: Zlowout, Gra, Rin
  - then T0
REQ-018 NOP (opcode 13) and every undefined opcode (15-31) SHALL assert nothing in T3 and then go to T0.
REQ-019 HALT (opcode 14) SHALL assert nothing in T3 and then go to HALT.
REQ-020 HALT SHALL drive all strobes low with Run=0, and SHALL be left only via clear.
REQ-021 Stop SHALL be sampled only on the edge leaving an instruction's final state; if Stop=1 there, the next state SHALL be HALT instead of T0. Stop in any other state SHALL NOT shorten the current instruction.
REQ-022 Instruction latency SHALL be: ALU 6 cycles, MUL/DIV 7, NEG/NOT 5, NOP/illegal 4 (T0 through the last state, inclusive).

Reset
REQ-023 While clear=1, the state SHALL be IDLE immediately (asynchronously), all strobes SHALL be 0 and Run=1, including when clear asserts mid-instruction.
REQ-024 After clear deasserts, the first rising edge SHALL enter T0.

Verification
REQ-025 shl R7,R0,R4 (IR=0x3B820000) -> T3: Grb/Rout/Yin; T4: Grc/Rout/Zlowin with ALUop=7; T5: Gra/Rin/Zlowout; then T0; 6 cycles total.
REQ-026 mul R3,R1 (IR=0x49880000) -> T4: Zlowin and Zhighin with ALUop=9; T5: LOin; T6: HIin; then T0; 7 cycles.
REQ-027 halt (IR=0x70000000) -> after T3, Run=0 and all strobes 0 for at least 20 cycles; clear pulse -> IDLE, then T0.
REQ-028 add with Stop=1 asserted during T4 only -> T5 still performs Rin, Stop is low at the T5 exit, so next state is T0; Stop held through T5 -> HALT.
REQ-029 clear asserted mid-T4 of a shl -> all strobes drop in the same cycle with no Rin; on release, T0 follows on the next edge.
REQ-030 illegal opcode 31 (IR=0xF8000000) -> no Rin, Rout, Yin or Zlowin in T3; T0 follows.
